idma_rw_burst_splitter: RTL and testbench
=========================================

// Module: idma_rw_burst_splitter
// PURPOSE
//  Front stage of the AXI read/write transport layer; feeds it directly. Accepts one 1-D transfer (src, dst, length).
//  Chops it into AXI4 INCR bursts on the read and write sides independently, per side legal on 4 KiB pages and MaxBeats.
//  Per read burst: emits AR meta plus the read datapath request. Per write burst: emits AW meta plus the write datapath request.
// PARAMETERS
//  AddrWidth   64   address width (bits)
//  DataWidth   64   bus width (bits); StrbWidth=DataWidth/8, OffW=$clog2(StrbWidth)
//  TFLenWidth  32   transfer length width (bytes)
//  MaxBeats    256  max beats per burst (power of two, 1..256)
//  idma_req_t, r_dp_req_t, w_dp_req_t, read_meta_channel_t, write_meta_channel_t  struct types
// PORTS
//  clk_i         in   1       clock
//  rst_ni        in   1       asynchronous reset, active low
//  req_i         in   struct  {src_addr, dst_addr, length}
//  req_valid_i   in   1       descriptor valid
//  req_ready_o   out  1       descriptor accepted when valid&ready
//  ar_req_o      out  struct  {addr, len[7:0], size=OffW, burst=INCR}
//  ar_valid_o / ar_ready_i      out/in  1   AR meta handshake
//  r_dp_req_o    out  struct  {offset, tailer, shift, is_single}
//  r_dp_valid_o / r_dp_ready_i  out/in  1   read dp handshake
//  aw_req_o      out  struct  {addr, len[7:0], size=OffW, burst=INCR}
//  aw_valid_o / aw_ready_i      out/in  1   AW meta handshake
//  w_dp_req_o    out  struct  {offset, tailer, shift, num_beats, is_single}
//  w_dp_valid_o / w_dp_ready_i  out/in  1   write dp handshake
//  busy_o        out  1       either side has remaining bytes
// BEHAVIOUR
//  - Reset: all *_valid_o=0, req_ready_o=1, busy_o=0, side state IDLE, counters 0. Reset mid-transfer discards remaining bursts.
//  - Per side FSM IDLE->BUSY on accept; BUSY->IDLE when the last burst has both meta and dp handshaked.
//  - req_ready_o=1 only when both sides IDLE (registered); a new descriptor is taken the cycle after the last handshake.
//  - Burst outputs are combinational from registered {addr, rem}. Meta and dp valid both rise 1 cycle after accept.
//  - Meta and dp handshake independently; per-side sent flags; valids drop once their own handshake completes.
//  - Advance (addr+=bytes, rem-=bytes, flags clear) when both handshakes of that side are done. Both in the same cycle gives 1 burst/cycle.
//  - Outputs stay stable while valid&!ready. Read and write sides never wait on each other within a transfer.
//  - bytes = min(rem, 4096-addr[11:0], MaxBeats*StrbWidth-addr[OffW-1:0]). Compute at TFLenWidth+1 bits, no overflow.
//  - len = ((addr[OffW-1:0]+bytes+StrbWidth-1)>>OffW)-1; is_single = (len==0); num_beats = len.
//  - offset = addr[OffW-1:0]; tailer = (StrbWidth-((addr+bytes) mod StrbWidth)) mod StrbWidth.
//  - Shifts are fixed for the whole transfer: r shift = src_addr[OffW-1:0]; w shift = (-dst_addr)[OffW-1:0].
//  - Final burst: rem==bytes -> side goes IDLE after both handshakes; busy_o falls the same cycle as the state change.
// CONFIGURATION
//  IDMA_BURST_SPLITTER_ZERO_LEN_EN defined:
//    length==0 is accepted (req_ready_o=1), emits nothing, and the block stays IDLE.
//  Macro undefined:
//    length==0 is illegal; a simulation assertion fires on accept and behaviour is unspecified.
// STRUCTURE
//  - Package idma_burst_splitter_pkg: burst_chunk_t {addr, len, offset, tailer, bytes}, function calc_chunk(addr, rem).
//  - Sub-module idma_burst_chopper holds one side: FSM, addr/rem regs, sent flags, meta+dp handshake.
//  - Top instantiates the chopper twice (read, write), adds the shift logic and the req_ready/busy glue.
// TESTING  (DataWidth=64, MaxBeats=256)
//  1. Aligned transfer: src=0x0, dst=0x0, len=64.
//     -> one AR {0x0, len 7}; r_dp {off 0, tail 0, shift 0}; one AW {0x0, len 7}; w_dp num_beats 7.
//  2. Page crossing: src=0xFF8, dst=0x0, len=16.
//     -> AR {0xFF8, len 0, single} then AR {0x1000, len 0}; one AW {0x0, len 1}.
//  3. Misaligned: src=0x3, dst=0x5, len=10.
//     -> AR {0x3, len 1}, r_dp {off 3, tail 3, shift 3}; AW {0x5, len 1}, w_dp {off 5, tail 1, shift 3}.
//  4. MaxBeats split: src=dst=0x0, len=4096.
//     -> AR/AW {0x000, len 255}, {0x800, len 255}; with all readies high, back-to-back cycles; busy_o falls after the 2nd handshake.
//  5. Backpressure: ar_ready_i=0 for 10 cycles, others 1, on test 4.
//     -> AR and r_dp stable, r_dp_valid drops after its handshake, the write side finishes both bursts, req_ready_o stays 0.
//  6. Reset and zero length: rst_ni low mid test 4 -> all valids 0 next edge, req_ready_o=1.
//     len=0 with the macro -> no output valid; without the macro -> assertion fires.

Source files
------------

// File: rtl/idma_burst_splitter_pkg.sv
// Shared types, widths and the burst-chunk helper for the iDMA read/write burst splitter.
package idma_burst_splitter_pkg;

  localparam int unsigned AddrWidth  = 64;
  localparam int unsigned DataWidth  = 64;
  localparam int unsigned StrbWidth  = DataWidth / 8;
  localparam int unsigned OffW       = $clog2(StrbWidth);
  localparam int unsigned OffW1      = OffW + 1;
  localparam int unsigned TFLenWidth = 32;
  localparam int unsigned BytesWidth = TFLenWidth + 1;
  localparam int unsigned MaxBeats   = 256;
  localparam int unsigned PageBytes  = 4096;
  localparam int unsigned BurstBytes = MaxBeats * StrbWidth;

  localparam logic [1:0] BurstIncr = 2'b01;

  typedef logic [AddrWidth-1:0]  addr_t;
  typedef logic [TFLenWidth-1:0] tf_len_t;
  typedef logic [BytesWidth-1:0] bytes_t;
  typedef logic [OffW-1:0]       off_t;

  typedef enum logic {ST_IDLE, ST_BUSY} chop_state_e;

  typedef struct packed {
    addr_t   src_addr;
    addr_t   dst_addr;
    tf_len_t length;
  } idma_req_t;

  typedef struct packed {
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } read_meta_channel_t;

  typedef struct packed {
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } write_meta_channel_t;

  typedef struct packed {
    off_t offset;
    off_t tailer;
    off_t shift;
    logic is_single;
  } r_dp_req_t;

  typedef struct packed {
    off_t       offset;
    off_t       tailer;
    off_t       shift;
    logic [7:0] num_beats;
    logic       is_single;
  } w_dp_req_t;

  typedef struct packed {
    addr_t      addr;
    logic [7:0] len;
    off_t       offset;
    off_t       tailer;
    bytes_t     bytes;
  } burst_chunk_t;

  // Largest legal burst at addr: bounded by remaining bytes, the 4 KiB page and MaxBeats.
  function automatic burst_chunk_t calc_chunk(addr_t addr, tf_len_t rem);
    burst_chunk_t    c;
    bytes_t          page_left;
    bytes_t          beat_left;
    bytes_t          nbytes;
    bytes_t          span;
    off_t            end_off;
    logic [OffW:0]   tail_w;
    page_left = BytesWidth'(PageBytes) - BytesWidth'(addr[11:0]);
    beat_left = BytesWidth'(BurstBytes) - BytesWidth'(addr[OffW-1:0]);
    nbytes    = BytesWidth'(rem);
    if (page_left < nbytes) nbytes = page_left;
    if (beat_left < nbytes) nbytes = beat_left;
    span      = (BytesWidth'(addr[OffW-1:0]) + nbytes + BytesWidth'(StrbWidth - 1)) >> OffW;
    end_off   = addr[OffW-1:0] + nbytes[OffW-1:0];
    tail_w    = OffW1'(StrbWidth) - {1'b0, end_off};
    c.addr    = addr;
    c.len     = 8'(span - BytesWidth'(1));
    c.offset  = addr[OffW-1:0];
    c.tailer  = tail_w[OffW-1:0];
    c.bytes   = nbytes;
    return c;
  endfunction

endpackage

// File: rtl/idma_burst_chopper.sv
// One side (read or write) of the burst splitter: walks a transfer in legal AXI bursts with
// independent meta and datapath handshakes per burst.
module idma_burst_chopper
  import idma_burst_splitter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start,
  input  addr_t      start_addr,
  input  tf_len_t    start_len,
  output addr_t      burst_addr,
  output logic [7:0] burst_len,
  output off_t       burst_offset,
  output off_t       burst_tailer,
  output logic       meta_valid,
  input  logic       meta_ready,
  output logic       dp_valid,
  input  logic       dp_ready,
  output logic       idle_nxt_c
);

  chop_state_e  state_q, state_d;
  addr_t        addr_q, addr_d;
  tf_len_t      rem_q, rem_d;
  logic         meta_valid_q, meta_valid_d;
  logic         dp_valid_q, dp_valid_d;
  burst_chunk_t chunk;
  logic         meta_done, dp_done, last;

  assign chunk        = calc_chunk(addr_q, rem_q);
  assign burst_addr   = chunk.addr;
  assign burst_len    = chunk.len;
  assign burst_offset = chunk.offset;
  assign burst_tailer = chunk.tailer;
  assign meta_valid   = meta_valid_q;
  assign dp_valid     = dp_valid_q;

  // A handshake counts as done if it completes now or already completed for this burst.
  assign meta_done = !meta_valid_q || meta_ready;
  assign dp_done   = !dp_valid_q || dp_ready;
  assign last      = ({1'b0, rem_q} == chunk.bytes);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    meta_valid_d = meta_valid_q;
    dp_valid_d   = dp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_BUSY;
          addr_d       = start_addr;
          rem_d        = start_len;
          meta_valid_d = 1'b1;
          dp_valid_d   = 1'b1;
        end
      end
      ST_BUSY: begin
        if (meta_done && dp_done) begin
          if (last) begin
            state_d      = ST_IDLE;
            meta_valid_d = 1'b0;
            dp_valid_d   = 1'b0;
          end else begin
            addr_d       = addr_q + AddrWidth'(chunk.bytes);
            rem_d        = rem_q - TFLenWidth'(chunk.bytes);
            meta_valid_d = 1'b1;
            dp_valid_d   = 1'b1;
          end
        end else begin
          meta_valid_d = meta_valid_q && !meta_ready;
          dp_valid_d   = dp_valid_q && !dp_ready;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    idle_nxt_c = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      meta_valid_q <= 1'b0;
      dp_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      meta_valid_q <= meta_valid_d;
      dp_valid_q   <= dp_valid_d;
    end
  end

endmodule

// File: rtl/idma_rw_burst_splitter.sv
// Splits one 1-D transfer into AXI4 INCR read and write bursts, each side independently.
// IDMA_BURST_SPLITTER_ZERO_LEN_EN: accept zero-length descriptors as no-ops.
module idma_rw_burst_splitter
  import idma_burst_splitter_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  idma_req_t           req_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  output read_meta_channel_t  ar_req_o,
  output logic                ar_valid_o,
  input  logic                ar_ready_i,
  output r_dp_req_t           r_dp_req_o,
  output logic                r_dp_valid_o,
  input  logic                r_dp_ready_i,
  output write_meta_channel_t aw_req_o,
  output logic                aw_valid_o,
  input  logic                aw_ready_i,
  output w_dp_req_t           w_dp_req_o,
  output logic                w_dp_valid_o,
  input  logic                w_dp_ready_i,
  output logic                busy_o
);

  logic       accept, start;
  logic       ready_q, busy_q;
  off_t       r_shift_q, w_shift_q;
  addr_t      r_addr, w_addr;
  logic [7:0] r_len, w_len;
  off_t       r_offset, r_tailer, w_offset, w_tailer;
  logic       r_idle_nxt, w_idle_nxt;

  assign accept = req_valid_i && ready_q;
`ifdef IDMA_BURST_SPLITTER_ZERO_LEN_EN
  assign start = accept && (req_i.length != '0);
`else
  assign start = accept;
`endif

  idma_burst_chopper u_read (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start        (start),
    .start_addr   (req_i.src_addr),
    .start_len    (req_i.length),
    .burst_addr   (r_addr),
    .burst_len    (r_len),
    .burst_offset (r_offset),
    .burst_tailer (r_tailer),
    .meta_valid   (ar_valid_o),
    .meta_ready   (ar_ready_i),
    .dp_valid     (r_dp_valid_o),
    .dp_ready     (r_dp_ready_i),
    .idle_nxt_c   (r_idle_nxt)
  );

  idma_burst_chopper u_write (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start        (start),
    .start_addr   (req_i.dst_addr),
    .start_len    (req_i.length),
    .burst_addr   (w_addr),
    .burst_len    (w_len),
    .burst_offset (w_offset),
    .burst_tailer (w_tailer),
    .meta_valid   (aw_valid_o),
    .meta_ready   (aw_ready_i),
    .dp_valid     (w_dp_valid_o),
    .dp_ready     (w_dp_ready_i),
    .idle_nxt_c   (w_idle_nxt)
  );

  // Shifts hold for the whole transfer, so they are latched once at accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      r_shift_q <= '0;
      w_shift_q <= '0;
    end else begin
      ready_q <= r_idle_nxt && w_idle_nxt;
      busy_q  <= !(r_idle_nxt && w_idle_nxt);
      if (accept) begin
        r_shift_q <= req_i.src_addr[OffW-1:0];
        w_shift_q <= off_t'(0) - req_i.dst_addr[OffW-1:0];
      end
    end
  end

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;

  always_comb begin
    ar_req_o.addr        = r_addr;
    ar_req_o.len         = r_len;
    ar_req_o.size        = 3'(OffW);
    ar_req_o.burst       = BurstIncr;
    r_dp_req_o.offset    = r_offset;
    r_dp_req_o.tailer    = r_tailer;
    r_dp_req_o.shift     = r_shift_q;
    r_dp_req_o.is_single = (r_len == 8'd0);
    aw_req_o.addr        = w_addr;
    aw_req_o.len         = w_len;
    aw_req_o.size        = 3'(OffW);
    aw_req_o.burst       = BurstIncr;
    w_dp_req_o.offset    = w_offset;
    w_dp_req_o.tailer    = w_tailer;
    w_dp_req_o.shift     = w_shift_q;
    w_dp_req_o.num_beats = w_len;
    w_dp_req_o.is_single = (w_len == 8'd0);
  end

`ifndef IDMA_BURST_SPLITTER_ZERO_LEN_EN
  zero_len_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_valid_i && req_ready_o) |-> (req_i.length != '0))
    else $error("zero-length descriptor accepted");
`endif

endmodule

// File: tb/tb_idma_rw_burst_splitter.sv
// Scoreboard bench for idma_rw_burst_splitter: a burst-list model fills per-channel queues,
// a negedge monitor pops and compares on every handshake.
module tb_idma_rw_burst_splitter;
  import idma_burst_splitter_pkg::*;

  logic clk, rst_n;
  idma_req_t req;
  logic req_valid, req_ready;
  read_meta_channel_t ar_req;   logic ar_valid, ar_ready;
  r_dp_req_t r_dp_req;          logic r_dp_valid, r_dp_ready;
  write_meta_channel_t aw_req;  logic aw_valid, aw_ready;
  w_dp_req_t w_dp_req;          logic w_dp_valid, w_dp_ready;
  logic busy;

  int tests = 0;
  int fails = 0;
  int mode  = 0;  // 0 random readies, 1 all high, 2 ar held low

  read_meta_channel_t  ar_q[$];
  r_dp_req_t           rdp_q[$];
  write_meta_channel_t aw_q[$];
  w_dp_req_t           wdp_q[$];

  idma_rw_burst_splitter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .ar_req_o(ar_req), .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
    .r_dp_req_o(r_dp_req), .r_dp_valid_o(r_dp_valid), .r_dp_ready_i(r_dp_ready),
    .aw_req_o(aw_req), .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
    .w_dp_req_o(w_dp_req), .w_dp_valid_o(w_dp_valid), .w_dp_ready_i(w_dp_ready),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected bursts straight from the splitting rules, one loop per side.
  task automatic model(input idma_req_t d);
    longint unsigned a, rem, b, off, lenv, sh;
    read_meta_channel_t  m;
    write_meta_channel_t wm;
    r_dp_req_t rd;
    w_dp_req_t wd;
    a = d.src_addr; rem = 64'(d.length); sh = d.src_addr % 8;
    while (rem > 0) begin
      off = a % 8; b = rem;
      if (4096 - (a % 4096) < b) b = 4096 - (a % 4096);
      if (2048 - off < b) b = 2048 - off;
      lenv = (off + b + 7) / 8 - 1;
      m.addr = a; m.len = 8'(lenv); m.size = 3'd3; m.burst = 2'b01;
      rd.offset = 3'(off); rd.tailer = 3'((8 - ((a + b) % 8)) % 8);
      rd.shift = 3'(sh); rd.is_single = (lenv == 0);
      ar_q.push_back(m); rdp_q.push_back(rd);
      a += b; rem -= b;
    end
    a = d.dst_addr; rem = 64'(d.length); sh = (8 - d.dst_addr % 8) % 8;
    while (rem > 0) begin
      off = a % 8; b = rem;
      if (4096 - (a % 4096) < b) b = 4096 - (a % 4096);
      if (2048 - off < b) b = 2048 - off;
      lenv = (off + b + 7) / 8 - 1;
      wm.addr = a; wm.len = 8'(lenv); wm.size = 3'd3; wm.burst = 2'b01;
      wd.offset = 3'(off); wd.tailer = 3'((8 - ((a + b) % 8)) % 8);
      wd.shift = 3'(sh); wd.num_beats = 8'(lenv); wd.is_single = (lenv == 0);
      aw_q.push_back(wm); wdp_q.push_back(wd);
      a += b; rem -= b;
    end
  endtask

  task automatic send(input logic [63:0] src, input logic [63:0] dst, input logic [31:0] len);
    int n = 0;
    while (!req_ready && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      tests++; fails++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    req.src_addr = src; req.dst_addr = dst; req.length = len;
    req_valid = 1'b1;
    model(req);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(req_ready && !busy) && n < 3000) begin @(negedge clk); n++; end
    chk({name, "_done"}, 128'(n < 3000), 128'(1));
    chk({name, "_drain"}, 128'(ar_q.size() + rdp_q.size() + aw_q.size() + wdp_q.size()), 128'(0));
  endtask

  // Readies change just after posedge so the negedge monitor sees what the DUT will see.
  initial begin
    ar_ready = 0; r_dp_ready = 0; aw_ready = 0; w_dp_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (mode)
        1: begin ar_ready = 1; r_dp_ready = 1; aw_ready = 1; w_dp_ready = 1; end
        2: begin ar_ready = 0; r_dp_ready = 1; aw_ready = 1; w_dp_ready = 1; end
        default: begin
          ar_ready = ($urandom % 4) != 0; r_dp_ready = ($urandom % 3) != 0;
          aw_ready = ($urandom % 4) != 0; w_dp_ready = ($urandom % 2) != 0;
        end
      endcase
    end
  end

  initial begin
    logic ar_hold = 1'b0;
    read_meta_channel_t ar_prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ar_hold = 1'b0;
      end else begin
        if (ar_hold) chk("ar_stable", 128'({ar_valid, ar_req}), 128'({1'b1, ar_prev}));
        ar_hold = ar_valid && !ar_ready;
        ar_prev = ar_req;
        if (ar_valid && ar_ready) begin
          if (ar_q.size() == 0) chk("ar_unexpected", 128'(ar_req), 128'(0) - 1);
          else chk("ar", 128'(ar_req), 128'(ar_q.pop_front()));
        end
        if (r_dp_valid && r_dp_ready) begin
          if (rdp_q.size() == 0) chk("r_dp_unexpected", 128'(r_dp_req), 128'(0) - 1);
          else chk("r_dp", 128'(r_dp_req), 128'(rdp_q.pop_front()));
        end
        if (aw_valid && aw_ready) begin
          if (aw_q.size() == 0) chk("aw_unexpected", 128'(aw_req), 128'(0) - 1);
          else chk("aw", 128'(aw_req), 128'(aw_q.pop_front()));
        end
        if (w_dp_valid && w_dp_ready) begin
          if (wdp_q.size() == 0) chk("w_dp_unexpected", 128'(w_dp_req), 128'(0) - 1);
          else chk("w_dp", 128'(w_dp_req), 128'(wdp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [63:0] s, d;
    logic [31:0] l;
    rst_n = 1'b0; req = '0; req_valid = 1'b0;
    #12;
    chk("reset_valids", 128'({ar_valid, r_dp_valid, aw_valid, w_dp_valid}), 128'(0));
    chk("reset_ready", 128'(req_ready), 128'(1));
    chk("reset_busy", 128'(busy), 128'(0));
    @(negedge clk); rst_n = 1'b1;

    mode = 1;
    repeat (2) @(posedge clk);
    send(64'h0, 64'h0, 32'd64);       wait_done("aligned");
    send(64'hFF8, 64'h0, 32'd16);     wait_done("page_cross");
    send(64'h3, 64'h5, 32'd10);       wait_done("misaligned");

    // MaxBeats split with all readies high: bursts on consecutive edges.
    send(64'h0, 64'h0, 32'd4096);
    @(negedge clk); chk("split_busy1", 128'(busy), 128'(1));
    @(negedge clk); chk("split_busy2", 128'(busy), 128'(1));
    @(negedge clk); chk("split_busy_fall", 128'({busy, req_ready}), 128'(2'b01));
    wait_done("split");

    // AR backpressure: write side and r_dp finish while AR waits.
    mode = 2;
    repeat (2) @(posedge clk);
    send(64'h0, 64'h0, 32'd4096);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk("bp_req_ready", 128'(req_ready), 128'(0));
    end
    chk("bp_side_state", 128'({ar_valid, r_dp_valid, aw_valid, w_dp_valid}), 128'(4'b1000));
    mode = 1;
    wait_done("backpressure");

    // Reset in the middle of a transfer discards the remaining bursts.
    send(64'h0, 64'h0, 32'd4096);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valids", 128'({ar_valid, r_dp_valid, aw_valid, w_dp_valid}), 128'(0));
    chk("midrst_ready", 128'({req_ready, busy}), 128'(2'b10));
    ar_q.delete(); rdp_q.delete(); aw_q.delete(); wdp_q.delete();
    @(negedge clk); rst_n = 1'b1;

`ifdef IDMA_BURST_SPLITTER_ZERO_LEN_EN
    send(64'h100, 64'h200, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("zero_len", 128'({ar_valid, r_dp_valid, aw_valid, w_dp_valid, req_ready, busy}),
          128'(6'b000010));
    end
`endif

    mode = 0;
    for (int t = 0; t < 40; t++) begin
      s = 64'($urandom_range(0, 65535)) + (64'($urandom_range(0, 3)) << 32);
      d = 64'($urandom_range(0, 65535)) + (64'($urandom_range(0, 3)) << 32);
      l = ($urandom % 2) ? 32'($urandom_range(1, 40)) : 32'($urandom_range(1, 6000));
      send(s, d, l);
      wait_done("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
